// File: rtl/mips_timer_pkg.sv
// Shared register map, CTRL bit positions and FSM encodings for the
// memory-mapped MIPS timer.
package mips_timer_pkg;

   // Word offsets within the window, decoded from memaddr[4:2]
   localparam logic [2:0] TMR_CTRL     = 3'd0;
   localparam logic [2:0] TMR_COUNT    = 3'd1;
   localparam logic [2:0] TMR_COMPARE  = 3'd2;
   localparam logic [2:0] TMR_STATUS   = 3'd3;
   localparam logic [2:0] TMR_PRESCALE = 3'd4;
   localparam logic [2:0] TMR_STATE    = 3'd5;

   localparam int CTRL_EN = 0;
   localparam int CTRL_AR = 1;
   localparam int CTRL_IE = 2;

   typedef enum logic [1:0] {
      TMR_STOP = 2'b00,
      TMR_RUN  = 2'b01,
      TMR_HALT = 2'b10
   } tmr_state_t;

endpackage

// File: rtl/mips_timer_prescale.sv
// 8-bit prescaler: pulses tick once every limit+1 cycles while run is high.
module mips_timer_prescale (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       clr,
   input  logic [7:0] limit,
   output logic       tick
);

   logic [7:0] pcnt;

   assign tick = run && (pcnt == limit);

   always_ff @(posedge clk) begin
      if (reset || clr || !run)
         pcnt <= 8'd0;
      else if (pcnt == limit)
         pcnt <= 8'd0;
      else
         pcnt <= pcnt + 8'd1;
   end

endmodule

// File: rtl/mips_timer.sv
// Memory-mapped 32-bit timer on the MIPS data port.
// Define MIPS_TIMER_IRQ_EN to implement CTRL.ie and the level interrupt.
module mips_timer
   import mips_timer_pkg::*;
#(
   parameter logic [31:0] BASE = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] memaddr,
   input  logic [31:0] memwritedata,
   output logic [31:0] memreaddata,
   output logic        sel,
   output logic        irq
);

   logic [2:0]  off;
   logic        wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;
   logic        ctrl_en, ctrl_ar, ctrl_ie_rd;
   logic [31:0] count, compare;
   logic        status_match;
   logic [7:0]  prescale;
   logic        tick, match;
   logic        unused_addr;
   tmr_state_t  state, next_state;

   assign unused_addr = ^memaddr[1:0];
   assign off         = memaddr[4:2];
   assign sel         = (memaddr[31:5] == BASE[31:5]);
   assign wr_ctrl     = memwrite && sel && (off == TMR_CTRL);
   assign wr_count    = memwrite && sel && (off == TMR_COUNT);
   assign wr_compare  = memwrite && sel && (off == TMR_COMPARE);
   assign wr_status   = memwrite && sel && (off == TMR_STATUS);
   assign wr_prescale = memwrite && sel && (off == TMR_PRESCALE);

   assign match = tick && ((count + 32'd1) == compare);

   mips_timer_prescale u_prescale (
      .clk   (clk),
      .reset (reset),
      .run   (state == TMR_RUN),
      .clr   (wr_ctrl),
      .limit (prescale),
      .tick  (tick)
   );

`ifdef MIPS_TIMER_IRQ_EN
   logic ctrl_ie;
   assign ctrl_ie_rd = ctrl_ie;
   assign irq        = status_match & ctrl_ie;
`else
   assign ctrl_ie_rd = 1'b0;
   assign irq        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= TMR_STOP;
      else
         state <= next_state;
   end

   // A CPU CTRL write always decides the next state, even on a one-shot match edge
   always_comb begin
      next_state = state;
      case (state)
         TMR_STOP: if (wr_ctrl && memwritedata[CTRL_EN]) next_state = TMR_RUN;
         TMR_RUN: begin
            if (wr_ctrl)
               next_state = memwritedata[CTRL_EN] ? TMR_RUN : TMR_STOP;
            else if (match && !ctrl_ar)
               next_state = TMR_HALT;
         end
         TMR_HALT: if (wr_ctrl) next_state = memwritedata[CTRL_EN] ? TMR_RUN : TMR_STOP;
         default: next_state = TMR_STOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_en      <= 1'b0;
         ctrl_ar      <= 1'b0;
`ifdef MIPS_TIMER_IRQ_EN
         ctrl_ie      <= 1'b0;
`endif
         count        <= 32'd0;
         compare      <= 32'hFFFF_FFFF;
         status_match <= 1'b0;
         prescale     <= 8'd0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en <= memwritedata[CTRL_EN];
            ctrl_ar <= memwritedata[CTRL_AR];
`ifdef MIPS_TIMER_IRQ_EN
            ctrl_ie <= memwritedata[CTRL_IE];
`endif
         end else if (match && !ctrl_ar) begin
            ctrl_en <= 1'b0;
         end

         // A one-shot match parks COUNT on COMPARE; autoreload restarts from 0
         if (wr_count)
            count <= memwritedata;
         else if (match)
            count <= ctrl_ar ? 32'd0 : compare;
         else if (tick)
            count <= count + 32'd1;

         if (wr_compare)
            compare <= memwritedata;

         if (match)
            status_match <= 1'b1;
         else if (wr_status && memwritedata[0])
            status_match <= 1'b0;

         if (wr_prescale)
            prescale <= memwritedata[7:0];
      end
   end

   always_comb begin
      memreaddata = 32'd0;
      if (sel) begin
         case (off)
            TMR_CTRL:     memreaddata = {29'd0, ctrl_ie_rd, ctrl_ar, ctrl_en};
            TMR_COUNT:    memreaddata = count;
            TMR_COMPARE:  memreaddata = compare;
            TMR_STATUS:   memreaddata = {31'd0, status_match};
            TMR_PRESCALE: memreaddata = {24'd0, prescale};
            TMR_STATE:    memreaddata = {30'd0, state};
            default:      memreaddata = 32'd0;
         endcase
      end
   end

endmodule
